systolic_drain: RTL and testbench
=================================

SYSTOLIC_DRAIN -- requirements
Module: systolic_drain

Interface
REQ-001 Parameter N, default 4: number of array columns drained.
REQ-002 Parameter DW, default 32: width of one partial-sum word.
REQ-003 Parameter DEPTH, default 4: output FIFO depth in row vectors; power of two, at least 2.
REQ-004 CLK  in  1  sole clock; all state updates on posedge CLK.
REQ-005 RESET  in  1  asynchronous, active-high reset.
REQ-006 EN  in  1  array advance strobe, the same strobe driven to the PEs; the drain shifts only when EN=1.
REQ-007 START  in  1  single-cycle pulse that arms a tile of TILE_ROWS result rows.
REQ-008 TILE_ROWS  in  8  number of rows in the tile, sampled on START; a value of 0 is treated as 256.
REQ-009 COL0_VALID  in  1  qualifies in_sum_bus column 0 in an EN cycle.
REQ-010 in_sum_bus  in  N*DW  bottom-row out_sum values; column j occupies bits [j*DW +: DW].
REQ-011 STALL  out  1  request to the controller to hold EN low.
REQ-012 row_data  out  N*DW  de-skewed result row; column 0 in the LSBs.
REQ-013 row_valid  out  1  row_data is valid.
REQ-014 row_ready  in  1  consumer accepts the row.
REQ-015 row_last  out  1  marks the final row of the tile; qualified by row_valid.
REQ-016 BUSY  out  1  high from START until the last row of the tile is popped.
REQ-017 OVF  out  1  sticky overflow error flag.

Function
REQ-018 Timing model: column j data for a given row arrives exactly j EN-cycles after column 0 data.
- Valid is carried only for column 0, as COL0_VALID.
REQ-019 Valid skew chain: COL0_VALID is delayed through an N-1 stage chain that shifts only on EN.
REQ-020 Data de-skew: column j is delayed by N-1-j EN-gated register stages.
- Column N-1 is used directly.
- All columns of one row are therefore aligned in the same EN cycle.
REQ-021 Row push: a row is pushed into the FIFO in the cycle where EN=1 and the last valid-chain stage is 1.
- For N=1, the push is qualified by COL0_VALID directly.
REQ-022 Pipeline latency: push occurs on the (N-1)th EN cycle after column-0 arrival.
- row_valid rises one CLK after the push.
REQ-023 FIFO handshake: a pop occurs when row_valid=1 and row_ready=1.
- row_data and row_last are held stable while row_valid=1 and row_ready=0.
REQ-024 Simultaneous push and pop when full is not a case: push-when-full is defined by REQ-026 regardless of a same-cycle pop.
- Simultaneous push and pop at any other occupancy leaves the count unchanged.
REQ-025 STALL = (count >= DEPTH-1), combinational from the registered count.
REQ-026 Push while count==DEPTH: the row is dropped, the FIFO is unchanged, and OVF is set.
- OVF stays set until RESET.
REQ-027 FSM states: IDLE, DRAIN, FLUSH.
- IDLE -> DRAIN on START; rows_left is loaded from TILE_ROWS.
- In DRAIN, each accepted push decrements rows_left; the push that makes rows_left 0 carries last=1 and moves the FSM to FLUSH.
- FLUSH -> IDLE when the last=1 row is popped.
REQ-028 START outside IDLE is ignored.
REQ-029 A push in IDLE is still stored in the FIFO, with last=0.
REQ-030 A dropped push (REQ-026) does not decrement rows_left.
REQ-031 BUSY = (state != IDLE).
REQ-032 Arithmetic: the drain passes data unmodified and performs no rounding or saturation.
- rows_left is 9 bits wide so that 256 is representable.
REQ-033 EN=0 freezes all delay and valid chains.
- The FIFO pop side remains active while EN=0.

Reset
REQ-034 While RESET=1, the following are cleared asynchronously: all delay stages and the valid chain to 0; the FIFO pointers and count to 0; the state to IDLE; rows_left to 0; OVF to 0.
REQ-035 Output values during and after reset: row_valid=0, row_last=0, STALL=0, BUSY=0, row_data=0.
REQ-036 Reset mid-tile discards all in-flight and buffered rows; no row is emitted after reset until new valid data arrives.

Structure
REQ-037 A shared package holds the FSM state encoding (IDLE=2'd0, DRAIN=2'd1, FLUSH=2'd2) and the default parameter constants.
REQ-038 The FIFO is a single sub-module, drain_fifo.
- Width is N*DW+1; the extra bit carries the last flag.
- It has registered pointers and a count, with no combinational path from row_ready to STALL.
REQ-039 The de-skew chains are generated inline in systolic_drain, not as sub-modules.

Verification
REQ-040 Single row, N=4, TILE_ROWS=1: START, then EN held 1 and column j driven with 100+j on the EN cycle j after COL0_VALID.
- Required: one row {103,102,101,100} (column 3 in the MSBs) with row_last=1.
- BUSY falls the cycle after the pop.
REQ-041 Streaming, TILE_ROWS=8, row_ready=1: rows r=0..7 with column j = 16*r+j.
- Required: 8 rows popped in order, row_last=1 only on r=7, and STALL never asserted.
REQ-042 Backpressure, row_ready=0, controller obeys STALL: STALL rises when count reaches 3 (DEPTH=4).
- Required: no row lost, OVF stays 0, and order is preserved when row_ready is reasserted.
REQ-043 Overflow, row_ready=0, EN forced to 1 regardless of STALL: 5 rows pushed.
- Required: 4 rows stored, the fifth dropped, OVF=1 sticky, and rows_left decremented only 4 times.
REQ-044 EN gaps: EN toggles 1,0,0,1 between column arrivals.
- Required: rows still de-skewed correctly and no spurious push while EN=0.
REQ-045 Reset mid-tile: RESET pulsed with 2 rows buffered and 1 row in the chains.
- Required: row_valid=0 immediately, BUSY=0, OVF=0, and no stale row emitted afterwards.

Source files
------------

// File: rtl/systolic_drain_pkg.sv
// Shared definitions for the systolic array drain.
// Holds the drain FSM state encoding, the default parameter values and a
// helper that converts the 8-bit tile row count into the 9-bit down-counter
// load value.
package systolic_drain_pkg;

  localparam int unsigned N_DEF     = 4;
  localparam int unsigned DW_DEF    = 32;
  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned ROWS_W    = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } drain_state_e;

  // A tile row count of 0 encodes a full 256-row tile.
  function automatic logic [ROWS_W-1:0] tile_rows_load(input logic [7:0] tile_rows);
    return (tile_rows == 8'd0) ? ROWS_W'(256) : ROWS_W'(tile_rows);
  endfunction

endpackage

// File: rtl/drain_fifo.sv
// Row FIFO for the systolic drain.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   push_i        write request; ignored while full
//   pop_i         read request; ignored while empty
//   din_i         write data
//   dout_o        head entry, forced to 0 while empty
//   valid_o       FIFO holds at least one entry
//   full_o        count == DEPTH
//   stall_o       count >= DEPTH-1, from the registered count only
module drain_fifo #(
  parameter int unsigned W     = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         valid_o,
  output logic         full_o,
  output logic         stall_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_en;
  logic          rd_en;

  assign wr_en = push_i && !full_o;
  assign rd_en = pop_i && valid_o;

  // Storage array needs no reset; the output mux hides it while empty.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointer and occupancy next-state; pointers wrap since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (wr_en && !rd_en) begin
      count_d = count_q + CW'(1);
    end else if (!wr_en && rd_en) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign stall_o = (count_q >= CW'(DEPTH - 1));
  assign dout_o  = valid_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/systolic_drain.sv
// Drains the bottom row of an N-column systolic array into a row FIFO.
// Column j arrives j EN-cycles after column 0; each column is delayed by
// N-1-j EN-gated stages so a whole row lines up, then is pushed together
// with a tile-last flag. A small FSM counts rows of the current tile.
// Ports:
//   CLK, RESET     clock, asynchronous active-high reset
//   EN             array advance strobe; chains shift only when high
//   START          arms a tile of TILE_ROWS rows (0 means 256)
//   COL0_VALID     qualifies column 0 of in_sum_bus in an EN cycle
//   in_sum_bus     skewed bottom-row partial sums, column 0 in the LSBs
//   STALL          asks the controller to hold EN low (FIFO nearly full)
//   row_data       de-skewed row, column 0 in the LSBs
//   row_valid      row_data/row_last valid
//   row_ready      consumer accepts the row
//   row_last       final row of the tile
//   BUSY           a tile is in progress
//   OVF            sticky: a row was dropped because the FIFO was full
module systolic_drain
  import systolic_drain_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          EN,
  input  logic          START,
  input  logic [7:0]    TILE_ROWS,
  input  logic          COL0_VALID,
  input  logic [N*DW-1:0] in_sum_bus,
  output logic          STALL,
  output logic [N*DW-1:0] row_data,
  output logic          row_valid,
  input  logic          row_ready,
  output logic          row_last,
  output logic          BUSY,
  output logic          OVF
);

  localparam int unsigned FW = N * DW + 1;

  logic              push_c;
  logic              accept_c;
  logic              drop_c;
  logic              last_c;
  logic              pop_c;
  logic              fifo_full;
  logic [N*DW-1:0]   row_aligned;
  logic [FW-1:0]     fifo_dout;

  drain_state_e      state_q, state_d;
  logic [ROWS_W-1:0] rows_left_q, rows_left_d;
  logic              ovf_q, ovf_d;

  // Valid skew chain: the last stage marks a fully aligned row.
  if (N > 1) begin : g_vld_chain
    logic [N-2:0] vld_q;

    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        vld_q <= '0;
      end else if (EN) begin
        vld_q <= (vld_q << 1) | (N-1)'(COL0_VALID);
      end
    end

    assign push_c = EN && vld_q[N-2];
  end else begin : g_vld_direct
    assign push_c = EN && COL0_VALID;
  end

  // Per-column de-skew: column j sits N-1-j EN-cycles in its own shift chain.
  for (genvar j = 0; j < N; j++) begin : g_col
    if (j == N - 1) begin : g_direct
      assign row_aligned[j*DW +: DW] = in_sum_bus[j*DW +: DW];
    end else begin : g_dly
      localparam int unsigned STG = N - 1 - j;
      logic [DW-1:0] dly_q [STG];

      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          for (int s = 0; s < STG; s++) begin
            dly_q[s] <= '0;
          end
        end else if (EN) begin
          dly_q[0] <= in_sum_bus[j*DW +: DW];
          for (int s = 1; s < STG; s++) begin
            dly_q[s] <= dly_q[s-1];
          end
        end
      end

      assign row_aligned[j*DW +: DW] = dly_q[STG-1];
    end
  end

  // A push into a full FIFO is dropped and does not count against the tile.
  assign accept_c = push_c && !fifo_full;
  assign drop_c   = push_c && fifo_full;
  assign last_c   = (state_q == DRAIN) && (rows_left_q == ROWS_W'(1));
  assign pop_c    = row_valid && row_ready;

  drain_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .din_i   ({last_c, row_aligned}),
    .dout_o  (fifo_dout),
    .valid_o (row_valid),
    .full_o  (fifo_full),
    .stall_o (STALL)
  );

  assign row_data = fifo_dout[N*DW-1:0];
  assign row_last = fifo_dout[FW-1];

  // Tile FSM next-state: count accepted rows, wait for the last one to leave.
  always_comb begin
    state_d     = state_q;
    rows_left_d = rows_left_q;
    ovf_d       = ovf_q | drop_c;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          state_d     = DRAIN;
          rows_left_d = tile_rows_load(TILE_ROWS);
        end
      end
      DRAIN: begin
        if (accept_c) begin
          rows_left_d = rows_left_q - ROWS_W'(1);
          if (last_c) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (pop_c && row_last) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      rows_left_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_left_q <= rows_left_d;
      ovf_q       <= ovf_d;
    end
  end

  assign BUSY = (state_q != IDLE);
  assign OVF  = ovf_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain (N=4, DW=32, DEPTH=4).
module tb_systolic_drain;

  localparam int unsigned N     = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

  logic            CLK = 1'b0;
  logic            RESET = 1'b1;
  logic            EN = 1'b0;
  logic            START = 1'b0;
  logic [7:0]      TILE_ROWS = 8'd0;
  logic            COL0_VALID = 1'b0;
  logic [N*DW-1:0] in_sum_bus = '0;
  logic            STALL;
  logic [N*DW-1:0] row_data;
  logic            row_valid;
  logic            row_ready = 1'b0;
  logic            row_last;
  logic            BUSY;
  logic            OVF;

  int checks = 0;
  int passed = 0;

  logic [DW-1:0] vals [16][N];
  logic [N*DW:0] got [$];
  bit            mon_on = 1'b0;
  bit            stall_seen = 1'b0;

  systolic_drain #(.N(N), .DW(DW), .DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .EN         (EN),
    .START      (START),
    .TILE_ROWS  (TILE_ROWS),
    .COL0_VALID (COL0_VALID),
    .in_sum_bus (in_sum_bus),
    .STALL      (STALL),
    .row_data   (row_data),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .row_last   (row_last),
    .BUSY       (BUSY),
    .OVF        (OVF)
  );

  always #5 CLK = ~CLK;

  // Records every pop (sampled mid-cycle, takes effect at the next edge).
  always @(negedge CLK) begin
    if (mon_on) begin
      if (STALL) stall_seen = 1'b1;
      if (row_valid && row_ready) got.push_back({row_last, row_data});
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_vals(input int base, input int stride);
    for (int r = 0; r < 16; r++)
      for (int j = 0; j < N; j++)
        vals[r][j] = 32'(base + stride * r + j);
  endtask

  function automatic logic [N*DW:0] exp_row(input int r, input bit last);
    logic [N*DW:0] v;
    v[N*DW] = last;
    for (int j = 0; j < N; j++) v[j*DW +: DW] = vals[r][j];
    return v;
  endfunction

  task automatic do_start(input logic [7:0] rows);
    START = 1'b1;
    TILE_ROWS = rows;
    tick();
    START = 1'b0;
  endtask

  // Drive skewed rows: column j of row r appears on EN-cycle r+j.
  task automatic stream(input int nrows, input int kmax, input bit gaps, input bit obey);
    int k;
    int budget;
    k = 0;
    budget = 0;
    while (k <= kmax && budget < 400) begin
      budget++;
      if (obey && STALL) begin
        EN = 1'b0;
        COL0_VALID = 1'b0;
        tick();
        continue;
      end
      EN = 1'b1;
      COL0_VALID = (k < nrows);
      for (int j = 0; j < N; j++) begin
        if (k - j >= 0 && k - j < nrows) in_sum_bus[j*DW +: DW] = vals[k-j][j];
        else in_sum_bus[j*DW +: DW] = 32'hDEAD0000 | 32'(k);
      end
      tick();
      if (gaps && k < kmax) begin
        repeat (2) begin
          EN = 1'b0;
          COL0_VALID = 1'b1;
          in_sum_bus = {N{32'hBAD0BAD0}};
          tick();
        end
      end
      k++;
    end
    EN = 1'b0;
    COL0_VALID = 1'b0;
    if (budget >= 400) begin
      checks++;
      $display("FAIL stream_budget: stream stuck at k=%0d of %0d", k, kmax);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((BUSY || row_valid) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (BUSY || row_valid) $display("FAIL %s_timeout: BUSY=%b row_valid=%b still high", name, BUSY, row_valid);
    else passed++;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    #1;
    checks++; if (row_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", row_valid); else passed++;
    checks++; if (row_last !== 1'b0) $display("FAIL rst_last: got %b want 0", row_last); else passed++;
    checks++; if (STALL !== 1'b0) $display("FAIL rst_stall: got %b want 0", STALL); else passed++;
    checks++; if (BUSY !== 1'b0) $display("FAIL rst_busy: got %b want 0", BUSY); else passed++;
    checks++; if (OVF !== 1'b0) $display("FAIL rst_ovf: got %b want 0", OVF); else passed++;
    checks++; if (row_data !== '0) $display("FAIL rst_data: got %h want 0", row_data); else passed++;
    repeat (2) tick();
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_single_row();
    logic [N*DW-1:0] want;
    int n;
    want = {32'd103, 32'd102, 32'd101, 32'd100};
    set_vals(100, 0);
    row_ready = 1'b0;
    do_start(8'd1);
    checks++; if (BUSY !== 1'b1) $display("FAIL single_busy_start: got %b want 1", BUSY); else passed++;
    stream(1, 1 + N - 2, 1'b0, 1'b0);
    n = 0;
    while (!row_valid && n < 20) begin tick(); n++; end
    checks++; if (row_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", row_valid); else passed++;
    checks++; if (row_data !== want) $display("FAIL single_data: got %h want %h", row_data, want); else passed++;
    checks++; if (row_last !== 1'b1) $display("FAIL single_last: got %b want 1", row_last); else passed++;
    checks++; if (BUSY !== 1'b1) $display("FAIL single_busy_pre_pop: got %b want 1", BUSY); else passed++;
    row_ready = 1'b1;
    tick();
    checks++; if (BUSY !== 1'b0) $display("FAIL single_busy_post_pop: got %b want 0", BUSY); else passed++;
    checks++; if (row_valid !== 1'b0) $display("FAIL single_empty: got %b want 0", row_valid); else passed++;
    row_ready = 1'b0;
    tick();
  endtask

  task automatic test_streaming();
    logic [N*DW:0] g;
    set_vals(0, 16);
    got.delete();
    stall_seen = 1'b0;
    row_ready = 1'b1;
    mon_on = 1'b1;
    do_start(8'd8);
    stream(8, 8 + N - 2, 1'b0, 1'b0);
    wait_idle("stream");
    mon_on = 1'b0;
    checks++; if (got.size() != 8) $display("FAIL stream_count: got %0d want 8", got.size()); else passed++;
    for (int i = 0; i < 8; i++) begin
      g = 'x;
      if (i < got.size()) g = got[i];
      checks++;
      if (g !== exp_row(i, i == 7)) $display("FAIL stream_row%0d: got %h want %h", i, g, exp_row(i, i == 7));
      else passed++;
    end
    checks++; if (stall_seen !== 1'b0) $display("FAIL stream_stall: got %b want 0", stall_seen); else passed++;
    checks++; if (OVF !== 1'b0) $display("FAIL stream_ovf: got %b want 0", OVF); else passed++;
    row_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [N*DW:0] g;
    set_vals(32'h1000, 16);
    got.delete();
    row_ready = 1'b0;
    mon_on = 1'b1;
    do_start(8'd6);
    fork
      stream(6, 6 + N - 2, 1'b0, 1'b1);
      begin
        repeat (20) tick();
        checks++; if (STALL !== 1'b1) $display("FAIL bp_stall_high: got %b want 1", STALL); else passed++;
        checks++; if (row_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", row_valid); else passed++;
        checks++; if (OVF !== 1'b0) $display("FAIL bp_ovf_held: got %b want 0", OVF); else passed++;
        checks++; if (got.size() != 0) $display("FAIL bp_no_pop: got %0d pops want 0", got.size()); else passed++;
        row_ready = 1'b1;
      end
    join
    wait_idle("bp");
    mon_on = 1'b0;
    checks++; if (got.size() != 6) $display("FAIL bp_count: got %0d want 6", got.size()); else passed++;
    for (int i = 0; i < 6; i++) begin
      g = 'x;
      if (i < got.size()) g = got[i];
      checks++;
      if (g !== exp_row(i, i == 5)) $display("FAIL bp_row%0d: got %h want %h", i, g, exp_row(i, i == 5));
      else passed++;
    end
    checks++; if (OVF !== 1'b0) $display("FAIL bp_ovf: got %b want 0", OVF); else passed++;
    row_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [N*DW:0] g;
    int n;
    set_vals(32'h2000, 16);
    got.delete();
    row_ready = 1'b0;
    mon_on = 1'b1;
    do_start(8'd6);
    stream(5, 5 + N - 2, 1'b0, 1'b0);
    tick();
    checks++; if (OVF !== 1'b1) $display("FAIL ovf_set: got %b want 1", OVF); else passed++;
    checks++; if (STALL !== 1'b1) $display("FAIL ovf_stall: got %b want 1", STALL); else passed++;
    row_ready = 1'b1;
    n = 0;
    while (row_valid && n < 20) begin tick(); n++; end
    checks++; if (got.size() != 4) $display("FAIL ovf_stored: got %0d want 4", got.size()); else passed++;
    for (int i = 0; i < 4; i++) begin
      g = 'x;
      if (i < got.size()) g = got[i];
      checks++;
      if (g !== exp_row(i, 1'b0)) $display("FAIL ovf_row%0d: got %h want %h", i, g, exp_row(i, 1'b0));
      else passed++;
    end
    checks++; if (OVF !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", OVF); else passed++;
    checks++; if (BUSY !== 1'b1) $display("FAIL ovf_busy: got %b want 1", BUSY); else passed++;
    // Two rows remain in the tile if only four pushes were counted.
    set_vals(32'h3000, 16);
    got.delete();
    stream(2, 2 + N - 2, 1'b0, 1'b0);
    wait_idle("ovf_tail");
    checks++; if (got.size() != 2) $display("FAIL ovf_tail_count: got %0d want 2", got.size()); else passed++;
    for (int i = 0; i < 2; i++) begin
      g = 'x;
      if (i < got.size()) g = got[i];
      checks++;
      if (g !== exp_row(i, i == 1)) $display("FAIL ovf_tail_row%0d: got %h want %h", i, g, exp_row(i, i == 1));
      else passed++;
    end
    checks++; if (OVF !== 1'b1) $display("FAIL ovf_sticky_end: got %b want 1", OVF); else passed++;
    mon_on = 1'b0;
    row_ready = 1'b0;
  endtask

  task automatic test_en_gaps();
    logic [N*DW:0] g;
    set_vals(32'hA000, 16);
    got.delete();
    row_ready = 1'b1;
    mon_on = 1'b1;
    do_start(8'd3);
    stream(3, 3 + N - 2, 1'b1, 1'b0);
    wait_idle("gaps");
    repeat (4) tick();
    mon_on = 1'b0;
    checks++; if (got.size() != 3) $display("FAIL gaps_count: got %0d want 3", got.size()); else passed++;
    for (int i = 0; i < 3; i++) begin
      g = 'x;
      if (i < got.size()) g = got[i];
      checks++;
      if (g !== exp_row(i, i == 2)) $display("FAIL gaps_row%0d: got %h want %h", i, g, exp_row(i, i == 2));
      else passed++;
    end
    row_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_vals(32'hC000, 16);
    got.delete();
    row_ready = 1'b0;
    do_start(8'd5);
    stream(3, 4, 1'b0, 1'b0);
    checks++; if (row_valid !== 1'b1) $display("FAIL mid_pre_valid: got %b want 1", row_valid); else passed++;
    checks++; if (OVF !== 1'b1) $display("FAIL mid_pre_ovf: got %b want 1", OVF); else passed++;
    RESET = 1'b1;
    #1;
    checks++; if (row_valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", row_valid); else passed++;
    checks++; if (BUSY !== 1'b0) $display("FAIL mid_busy: got %b want 0", BUSY); else passed++;
    checks++; if (OVF !== 1'b0) $display("FAIL mid_ovf: got %b want 0", OVF); else passed++;
    checks++; if (row_data !== '0) $display("FAIL mid_data: got %h want 0", row_data); else passed++;
    tick();
    RESET = 1'b0;
    tick();
    row_ready = 1'b1;
    mon_on = 1'b1;
    EN = 1'b1;
    COL0_VALID = 1'b0;
    in_sum_bus = {N{32'h5555AAAA}};
    repeat (10) tick();
    EN = 1'b0;
    mon_on = 1'b0;
    checks++; if (got.size() != 0) $display("FAIL mid_stale: got %0d rows want 0", got.size()); else passed++;
    checks++; if (BUSY !== 1'b0) $display("FAIL mid_busy_after: got %b want 0", BUSY); else passed++;
    checks++; if (row_valid !== 1'b0) $display("FAIL mid_valid_after: got %b want 0", row_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_streaming();
    test_backpressure();
    test_overflow();
    test_en_gaps();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
